// File: rtl/sfr_file.sv
// sfr_file: special-function-register file for a small 8-bit core.
//
// Resolves the CPU file address (with indirect access through FSR), routes
// 10h-1Fh to an external RAM and implements TMR0/prescaler, STATUS, FSR,
// OSCCAL, GPIO, OPTION and TRIS locally. Reads have a uniform one-clock
// latency: the effective address is registered and rd_data_o is decoded
// from the registered address.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   addr_i/we_i/din_i CPU file address, write strobe, write data
//   rd_data_o         read data (one clk after addr_i)
//   ram_*             external GPR RAM (ram_dout_i valid one clk after ram_addr_o)
//   cyc_en_i          instruction-cycle strobe (TMR0 clock when T0CS=0)
//   opt_we_i/tris_we_i OPTION / TRIS load from din_i
//   alu_zdc_c_i/alu_upd_i  ALU {Z,DC,C} flags and per-bit update mask
//   pcl_i, pcl_we_o, pcl_wdata_o  PC low read value and write request
//   gpio_in_i, gpio_out_o, gpio_oe_o  port pins, output latch, output enable
module sfr_file (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] addr_i,
    input  logic       we_i,
    input  logic [7:0] din_i,
    output logic [7:0] rd_data_o,
    output logic       ram_we_o,
    output logic [4:0] ram_addr_o,
    output logic [7:0] ram_din_o,
    input  logic [7:0] ram_dout_i,
    input  logic       cyc_en_i,
    input  logic       opt_we_i,
    input  logic       tris_we_i,
    input  logic [2:0] alu_zdc_c_i,
    input  logic [2:0] alu_upd_i,
    input  logic [7:0] pcl_i,
    output logic       pcl_we_o,
    output logic [7:0] pcl_wdata_o,
    input  logic [3:0] gpio_in_i,
    output logic [3:0] gpio_out_o,
    output logic [3:0] gpio_oe_o
);

    localparam logic [4:0] A_INDF   = 5'h00;
    localparam logic [4:0] A_TMR0   = 5'h01;
    localparam logic [4:0] A_PCL    = 5'h02;
    localparam logic [4:0] A_STATUS = 5'h03;
    localparam logic [4:0] A_FSR    = 5'h04;
    localparam logic [4:0] A_OSCCAL = 5'h05;
    localparam logic [4:0] A_GPIO   = 5'h06;

    logic [4:0] fsr_q,    fsr_d;
    logic [4:0] eff_q;
    logic [2:0] zdc_q,    zdc_d;
    logic [7:0] tmr0_q,   tmr0_d;
    logic [7:0] psc_q,    psc_d;
    logic [1:0] inh_q,    inh_d;
    logic [6:0] osc_q,    osc_d;
    // OPTION bits 7:6 have no function here and are not stored.
    logic [5:0] opt_q,    opt_d;
    logic [3:0] tris_q,   tris_d;
    logic [3:0] gout_q,   gout_d;
    logic [3:0] sync1_q,  sync2_q;
    logic       t0_prev_q;

    logic [4:0] eff;
    logic       is_gpr;
    logic       wr_tmr0, wr_pcl, wr_status, wr_fsr, wr_osc, wr_gpio;
    logic       t0_rise, t0_fall, tick, tmr_inc;
    logic [7:0] ps_mask;

    // Effective address: addr 0 is INDF, i.e. indirect through FSR.
    assign eff    = (addr_i == A_INDF) ? fsr_q : addr_i;
    assign is_gpr = eff[4];

    assign ram_addr_o = eff - 5'd8;
    assign ram_din_o  = din_i;
    assign ram_we_o   = we_i & is_gpr;

    // INDF with FSR=0 resolves to eff 0 and so matches none of these.
    assign wr_tmr0   = we_i & (eff == A_TMR0);
    assign wr_pcl    = we_i & (eff == A_PCL);
    assign wr_status = we_i & (eff == A_STATUS);
    assign wr_fsr    = we_i & (eff == A_FSR);
    assign wr_osc    = we_i & (eff == A_OSCCAL);
    assign wr_gpio   = we_i & (eff == A_GPIO);

    assign pcl_we_o    = wr_pcl;
    assign pcl_wdata_o = din_i;
    assign gpio_out_o  = gout_q;
    assign gpio_oe_o   = ~tris_q;

    // T0CKI edges are taken from the synchronised pin, one flop later.
    assign t0_rise = sync2_q[2] & ~t0_prev_q;
    assign t0_fall = ~sync2_q[2] & t0_prev_q;
    assign tick    = opt_q[5] ? (opt_q[4] ? t0_fall : t0_rise) : cyc_en_i;
    // Prescaler terminal count: 2^(PS+1)-1, i.e. 1:2 .. 1:256.
    assign ps_mask = 8'((9'd2 << opt_q[2:0]) - 9'd1);

    always_comb begin
        fsr_d   = wr_fsr ? din_i[4:0] : fsr_q;
        osc_d   = wr_osc ? din_i[7:1] : osc_q;
        gout_d  = wr_gpio ? din_i[3:0] : gout_q;
        opt_d   = opt_we_i ? din_i[5:0] : opt_q;
        tris_d  = tris_we_i ? din_i[3:0] : tris_q;
        // CPU write first, then ALU-updated bits override it.
        zdc_d   = wr_status ? din_i[2:0] : zdc_q;
        zdc_d   = (zdc_d & ~alu_upd_i) | (alu_zdc_c_i & alu_upd_i);

        tmr0_d  = tmr0_q;
        psc_d   = psc_q;
        inh_d   = inh_q;
        tmr_inc = 1'b0;

        if (tick) begin
            if (opt_q[3]) begin
                tmr_inc = 1'b1;
            end else if (psc_q == ps_mask) begin
                psc_d   = 8'd0;
                tmr_inc = 1'b1;
            end else begin
                psc_d = psc_q + 8'd1;
            end
        end
        // After a TMR0 write the next two cyc_en strobes cannot increment it.
        if (cyc_en_i && inh_q != 2'd0)
            inh_d = inh_q - 2'd1;
        if (tmr_inc && inh_q == 2'd0)
            tmr0_d = tmr0_q + 8'd1;
        if (opt_we_i)
            psc_d = 8'd0;
        // A write wins over a coinciding tick, which is lost.
        if (wr_tmr0) begin
            tmr0_d = din_i;
            psc_d  = 8'd0;
            inh_d  = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsr_q     <= 5'h00;
            eff_q     <= 5'h00;
            zdc_q     <= 3'b000;
            tmr0_q    <= 8'h00;
            psc_q     <= 8'h00;
            inh_q     <= 2'd0;
            osc_q     <= 7'h7F;
            opt_q     <= 6'h3F;
            tris_q    <= 4'hF;
            gout_q    <= 4'h0;
            sync1_q   <= 4'h0;
            sync2_q   <= 4'h0;
            t0_prev_q <= 1'b0;
        end else begin
            fsr_q     <= fsr_d;
            eff_q     <= eff;
            zdc_q     <= zdc_d;
            tmr0_q    <= tmr0_d;
            psc_q     <= psc_d;
            inh_q     <= inh_d;
            osc_q     <= osc_d;
            opt_q     <= opt_d;
            tris_q    <= tris_d;
            gout_q    <= gout_d;
            sync1_q   <= gpio_in_i;
            sync2_q   <= sync1_q;
            t0_prev_q <= sync2_q[2];
        end
    end

    // Read mux on the registered address. TO and PD are fixed at 1.
    always_comb begin
        rd_data_o = 8'h00;
        if (eff_q[4]) begin
            rd_data_o = ram_dout_i;
        end else begin
            case (eff_q)
                A_TMR0:   rd_data_o = tmr0_q;
                A_PCL:    rd_data_o = pcl_i;
                A_STATUS: rd_data_o = {3'b000, 2'b11, zdc_q};
                A_FSR:    rd_data_o = {3'b111, fsr_q};
                A_OSCCAL: rd_data_o = {osc_q, 1'b0};
                A_GPIO:   rd_data_o = {4'h0, sync2_q};
                default:  rd_data_o = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_sfr_file.sv
module tb_sfr_file;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] addr;
    logic       we;
    logic [7:0] din;
    logic [7:0] rd_data;
    logic       ram_we;
    logic [4:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       cyc_en, opt_we, tris_we;
    logic [2:0] alu_zdc_c, alu_upd;
    logic [7:0] pcl;
    logic       pcl_we;
    logic [7:0] pcl_wdata;
    logic [3:0] gpio_in, gpio_out, gpio_oe;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] sb [$];
    logic [7:0] got, exp_v;

    always #5 clk = ~clk;

    sfr_file dut (
        .clk(clk), .rst(rst),
        .addr_i(addr), .we_i(we), .din_i(din), .rd_data_o(rd_data),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout),
        .cyc_en_i(cyc_en), .opt_we_i(opt_we), .tris_we_i(tris_we),
        .alu_zdc_c_i(alu_zdc_c), .alu_upd_i(alu_upd),
        .pcl_i(pcl), .pcl_we_o(pcl_we), .pcl_wdata_o(pcl_wdata),
        .gpio_in_i(gpio_in), .gpio_out_o(gpio_out), .gpio_oe_o(gpio_oe)
    );

    // External GPR RAM: synchronous write, registered read.
    logic [7:0] mem [0:31];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        addr = a; din = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] v);
        addr = a; we = 1'b0;
        tick();
        v = rd_data;
    endtask

    task automatic opt(input logic [7:0] d);
        din = d; opt_we = 1'b1;
        tick();
        opt_we = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_total++;
        if (rd_data !== 8'h00) $display("FAIL rst_rd got=%h exp=00", rd_data); else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_total++;
        if (gpio_oe !== 4'h0 || gpio_out !== 4'h0 || pcl_we !== 1'b0)
            $display("FAIL rst_outs got oe=%h out=%h pclwe=%b exp 0/0/0", gpio_oe, gpio_out, pcl_we);
        else n_pass++;
        sb.push_back(8'h18); rd(5'h03, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL rst_status got=%h exp=%h", got, exp_v); else n_pass++;
        sb.push_back(8'hE0); rd(5'h04, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL rst_fsr got=%h exp=%h", got, exp_v); else n_pass++;
        sb.push_back(8'h00); rd(5'h01, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL rst_tmr0 got=%h exp=%h", got, exp_v); else n_pass++;
    endtask

    task automatic test_indirect();
        wr(5'h04, 8'h15);
        sb.push_back(8'hF5); rd(5'h04, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL fsr_rd got=%h exp=%h", got, exp_v); else n_pass++;
        addr = 5'h00; din = 8'hA5; we = 1'b1; #1;
        n_total++;
        if (ram_we !== 1'b1 || ram_addr !== 5'h0D || ram_din !== 8'hA5)
            $display("FAIL indf_ram got we=%b a=%h d=%h exp 1/0d/a5", ram_we, ram_addr, ram_din);
        else n_pass++;
        tick(); we = 1'b0;
        sb.push_back(8'hA5); rd(5'h15, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL gpr15 got=%h exp=%h", got, exp_v); else n_pass++;
        sb.push_back(8'hA5); rd(5'h00, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL indf_rd got=%h exp=%h", got, exp_v); else n_pass++;
        addr = 5'h1F; din = 8'h3C; we = 1'b1; #1;
        n_total++; if (ram_addr !== 5'h17) $display("FAIL ram_addr_1f got=%h exp=17", ram_addr); else n_pass++;
        tick(); we = 1'b0;
        addr = 5'h10; din = 8'hC3; we = 1'b1; #1;
        n_total++; if (ram_addr !== 5'h08) $display("FAIL ram_addr_10 got=%h exp=08", ram_addr); else n_pass++;
        tick(); we = 1'b0;
        sb.push_back(8'h3C); rd(5'h1F, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL gpr1f got=%h exp=%h", got, exp_v); else n_pass++;
        sb.push_back(8'hC3); rd(5'h10, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL gpr10 got=%h exp=%h", got, exp_v); else n_pass++;
    endtask

    task automatic test_status();
        alu_upd = 3'b001; alu_zdc_c = 3'b000;
        wr(5'h03, 8'h07);
        alu_upd = 3'b000;
        sb.push_back(8'h1E); rd(5'h03, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL status_alu_win got=%h exp=%h", got, exp_v); else n_pass++;
        alu_upd = 3'b100; alu_zdc_c = 3'b000;
        tick();
        alu_upd = 3'b000;
        sb.push_back(8'h1A); rd(5'h03, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL status_alu_only got=%h exp=%h", got, exp_v); else n_pass++;
        wr(5'h03, 8'hFF);
        sb.push_back(8'h1F); rd(5'h03, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL status_ro got=%h exp=%h", got, exp_v); else n_pass++;
    endtask

    task automatic test_pcl_unimpl();
        pcl = 8'h5A;
        addr = 5'h02; din = 8'h40; we = 1'b1; #1;
        n_total++;
        if (pcl_we !== 1'b1 || pcl_wdata !== 8'h40 || ram_we !== 1'b0)
            $display("FAIL pcl_wr got we=%b d=%h ramwe=%b exp 1/40/0", pcl_we, pcl_wdata, ram_we);
        else n_pass++;
        tick(); we = 1'b0; #1;
        n_total++; if (pcl_we !== 1'b0) $display("FAIL pcl_we_drop got=%b exp=0", pcl_we); else n_pass++;
        sb.push_back(8'h5A); rd(5'h02, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL pcl_rd got=%h exp=%h", got, exp_v); else n_pass++;
        wr(5'h08, 8'h77);
        sb.push_back(8'h00); rd(5'h08, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL unimpl08 got=%h exp=%h", got, exp_v); else n_pass++;
        wr(5'h04, 8'h00);
        wr(5'h00, 8'h55);
        sb.push_back(8'h00); rd(5'h00, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL indf_null got=%h exp=%h", got, exp_v); else n_pass++;
        sb.push_back(8'hE0); rd(5'h04, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL indf_null_wr got=%h exp=%h", got, exp_v); else n_pass++;
    endtask

    task automatic test_osccal();
        sb.push_back(8'hFE); rd(5'h05, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL osc_rst got=%h exp=%h", got, exp_v); else n_pass++;
        wr(5'h05, 8'hFF);
        sb.push_back(8'hFE); rd(5'h05, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL osc_ff got=%h exp=%h", got, exp_v); else n_pass++;
        wr(5'h05, 8'h81);
        sb.push_back(8'h80); rd(5'h05, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL osc_81 got=%h exp=%h", got, exp_v); else n_pass++;
    endtask

    task automatic test_gpio();
        din = 8'h0A; tris_we = 1'b1; tick(); tris_we = 1'b0; #1;
        n_total++; if (gpio_oe !== 4'h5) $display("FAIL gpio_oe got=%h exp=5", gpio_oe); else n_pass++;
        wr(5'h06, 8'hF3);
        n_total++; if (gpio_out !== 4'h3) $display("FAIL gpio_out got=%h exp=3", gpio_out); else n_pass++;
        gpio_in = 4'h9; tick();
        sb.push_back(8'h09); rd(5'h06, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL gpio_rd got=%h exp=%h", got, exp_v); else n_pass++;
        gpio_in = 4'h4;
        sb.push_back(8'h09); rd(5'h06, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL gpio_sync1 got=%h exp=%h", got, exp_v); else n_pass++;
        sb.push_back(8'h04); rd(5'h06, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL gpio_sync2 got=%h exp=%h", got, exp_v); else n_pass++;
        gpio_in = 4'h0; repeat (4) tick();
    endtask

    task automatic test_tmr_write();
        logic [7:0] seq [5];
        seq[0] = 8'hFE; seq[1] = 8'hFE; seq[2] = 8'hFE; seq[3] = 8'hFF; seq[4] = 8'h00;
        cyc_en = 1'b0;
        opt(8'h08);
        addr = 5'h01; din = 8'hFE; we = 1'b1; cyc_en = 1'b1;
        sb.push_back(seq[0]);
        tick(); we = 1'b0;
        exp_v = sb.pop_front();
        n_total++; if (rd_data !== exp_v) $display("FAIL tmr_inh0 got=%h exp=%h", rd_data, exp_v); else n_pass++;
        for (int i = 1; i < 5; i++) begin
            sb.push_back(seq[i]);
            tick();
            exp_v = sb.pop_front();
            n_total++;
            if (rd_data !== exp_v) $display("FAIL tmr_inh%0d got=%h exp=%h", i, rd_data, exp_v); else n_pass++;
        end
        cyc_en = 1'b0;
    endtask

    task automatic test_prescale();
        cyc_en = 1'b0;
        pulse_rst();
        opt(8'h07);
        addr = 5'h01; we = 1'b0; cyc_en = 1'b1;
        for (int n = 1; n <= 65536; n++) begin
            if (n % 256 == 0 || n % 256 == 255) sb.push_back(8'((n / 256) % 256));
            tick();
            if (n % 256 == 0 || n % 256 == 255) begin
                exp_v = sb.pop_front();
                n_total++;
                if (rd_data !== exp_v) $display("FAIL psc n=%0d got=%h exp=%h", n, rd_data, exp_v); else n_pass++;
            end
        end
        cyc_en = 1'b0;
    endtask

    task automatic test_t0cki();
        cyc_en = 1'b0;
        pulse_rst();
        opt(8'h28);
        repeat (3) begin
            gpio_in = 4'h4; repeat (4) tick();
            gpio_in = 4'h0; repeat (4) tick();
        end
        sb.push_back(8'h03); rd(5'h01, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL t0_rise got=%h exp=%h", got, exp_v); else n_pass++;
        opt(8'h38);
        repeat (2) begin
            gpio_in = 4'h4; repeat (4) tick();
            gpio_in = 4'h0; repeat (4) tick();
        end
        sb.push_back(8'h05); rd(5'h01, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL t0_fall got=%h exp=%h", got, exp_v); else n_pass++;
    endtask

    task automatic test_rst_override();
        cyc_en = 1'b0;
        pulse_rst();
        din = 8'h00; tris_we = 1'b1; tick(); tris_we = 1'b0;
        wr(5'h04, 8'h1F);
        opt(8'h00);
        addr = 5'h01; cyc_en = 1'b1;
        repeat (20) tick();
        cyc_en = 1'b0;
        n_total++; if (rd_data !== 8'h0A) $display("FAIL mid_count got=%h exp=0a", rd_data); else n_pass++;
        n_total++; if (gpio_oe !== 4'hF) $display("FAIL oe_pre got=%h exp=f", gpio_oe); else n_pass++;
        rst = 1'b1; we = 1'b1; addr = 5'h04; din = 8'h1F; opt_we = 1'b1; tris_we = 1'b1;
        alu_upd = 3'b111; alu_zdc_c = 3'b111; cyc_en = 1'b1;
        tick();
        rst = 1'b0; we = 1'b0; opt_we = 1'b0; tris_we = 1'b0; alu_upd = 3'b000; cyc_en = 1'b0;
        #1;
        n_total++; if (gpio_oe !== 4'h0) $display("FAIL rst_oe got=%h exp=0", gpio_oe); else n_pass++;
        sb.push_back(8'hE0); rd(5'h04, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL rst_ovr_fsr got=%h exp=%h", got, exp_v); else n_pass++;
        sb.push_back(8'h18); rd(5'h03, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL rst_ovr_status got=%h exp=%h", got, exp_v); else n_pass++;
        sb.push_back(8'h00); rd(5'h01, got); exp_v = sb.pop_front();
        n_total++; if (got !== exp_v) $display("FAIL rst_ovr_tmr0 got=%h exp=%h", got, exp_v); else n_pass++;
        // OPTION back at FFh selects T0CKI, so cyc_en must not advance TMR0.
        cyc_en = 1'b1; repeat (5) tick(); cyc_en = 1'b0;
        n_total++; if (rd_data !== 8'h00) $display("FAIL rst_ovr_opt got=%h exp=00", rd_data); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; addr = 5'h00; we = 1'b0; din = 8'h00;
        cyc_en = 1'b0; opt_we = 1'b0; tris_we = 1'b0;
        alu_zdc_c = 3'b000; alu_upd = 3'b000; pcl = 8'h00; gpio_in = 4'h0;
        @(negedge clk);
        test_reset();
        test_indirect();
        test_status();
        test_pcl_unimpl();
        test_osccal();
        test_gpio();
        test_tmr_write();
        test_prescale();
        test_t0cki();
        test_rst_override();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sfr_file.md
SFR_FILE -- requirements
Module: sfr_file

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 system clock; rst in 1 reset; reset rst, synchronous, active-high; clock clk.
REQ-002 SHALL have CPU-side ports: addr in 5 f-address; we in 1 file write; din in 8 write data; rd_data out 8 read data.
REQ-003 SHALL have RAM-side ports: ram_we out 1; ram_addr out 5; ram_din out 8; ram_dout in 8, valid one clk after ram_addr is presented.
REQ-004 SHALL have core ports: cyc_en in 1 instruction-cycle strobe; opt_we in 1 OPTION load; tris_we in 1 TRIS load; alu_zdc_c in 3 {Z,DC,C}; alu_upd in 3 per-bit STATUS update mask; pcl in 8 current PC low; pcl_we out 1; pcl_wdata out 8.
REQ-005 SHALL have GPIO ports: gpio_in in 4; gpio_out out 4 latch; gpio_oe out 4, active-high output enable, equal to ~TRIS[3:0].

Function
REQ-006 SHALL resolve the effective address eff = (addr==0) ? FSR[4:0] : addr, combinationally.
REQ-007 SHALL decode eff as: 0 INDF; 1 TMR0; 2 PCL; 3 STATUS; 4 FSR; 5 OSCCAL; 6 GPIO; 07h-0Fh unimplemented; 10h-1Fh GPR.
REQ-008 For GPR, SHALL drive ram_addr=eff-8 (10h->08h, 1Fh->17h), ram_we=we, and ram_din=din, all combinational.
REQ-009 For non-GPR eff, SHALL hold ram_we=0; ram_addr and ram_din are don't-care.
REQ-010 SHALL register eff on every clk; rd_data SHALL reflect the registered eff, giving a uniform 1-clk read latency.
REQ-011 For a registered GPR eff, rd_data SHALL equal ram_dout.
REQ-012 For registered SFR eff, rd_data SHALL be the SFR value at that clk.
REQ-013 Unimplemented addresses and INDF with FSR[4:0]=0 SHALL read 00h; writes to them SHALL be ignored.
REQ-014 FSR SHALL read {3'b111,FSR[4:0]}; a write stores din[4:0].
REQ-015 STATUS SHALL read {3'b000,TO,PD,Z,DC,C}; TO and PD are read-only.
REQ-016 A STATUS write SHALL load bits 2:0 from din; for any bit with alu_upd set in the same clk, the ALU value SHALL win.
REQ-017 alu_upd SHALL update only its masked flags, on any clk.
REQ-018 A PCL write SHALL produce pcl_we=1 for one clk, with pcl_wdata=din, combinationally; PCL reads SHALL return pcl.
REQ-019 OSCCAL SHALL read/write bits 7:1; bit 0 SHALL read 0.
REQ-020 GPIO writes SHALL load gpio_out with din[3:0].
REQ-021 GPIO reads SHALL return {4'b0, gpio_in synchronised through two flops}.
REQ-022 opt_we SHALL load OPTION from din; tris_we SHALL load TRIS from din[3:0]; both are write-only.
REQ-023 OPTION fields: bit5 T0CS, bit4 T0SE, bit3 PSA, bits 2:0 PS.
REQ-024 TMR0 tick source: T0CS=0 -> each cyc_en; T0CS=1 -> synchronised gpio_in[2] edge, rising if T0SE=0, falling if T0SE=1.
REQ-025 With PSA=1, each tick SHALL increment TMR0.
REQ-026 With PSA=0, each tick SHALL increment an 8-bit prescaler; TMR0 SHALL increment when the prescaler wraps at 2^(PS+1) ticks (1:2 to 1:256).
REQ-027 TMR0 SHALL wrap FFh->00h with no flag.
REQ-028 A TMR0 write SHALL load din, clear the prescaler, and suppress TMR0 increments for the next 2 cyc_en strobes; a tick coinciding with the write SHALL be lost.
REQ-029 An opt_we SHALL clear the prescaler.
REQ-030 Writes SHALL take effect at the clk edge where we=1; a read of the same address on the next clk SHALL return the new value.

Reset
REQ-031 On rst, SHALL set: FSR=00h (reads E0h); STATUS Z,DC,C=0, TO=PD=1 (reads 18h).
REQ-032 On rst, SHALL set: TMR0=00h; prescaler=0; inhibit count=0; OSCCAL=FEh; OPTION=FFh; TRIS=Fh (gpio_oe=0); gpio_out=0; sync flops=0; registered eff=0 (rd_data=00h next clk).
REQ-033 rst SHALL override every write, opt_we, tris_we and alu_upd in the same clk; RAM contents are not affected.

Verification
REQ-034 Write FSR=15h, then write addr 0 with A5h -> ram_we=1, ram_addr=0Dh; read addr 15h -> rd_data=A5h one clk later.
REQ-035 OPTION=07h (T0CS=0, PSA=0, PS=7), cyc_en every clk -> TMR0 increments once per 256 strobes; after 65536 strobes TMR0=00h.
REQ-036 Write TMR0=FEh with cyc_en and PSA=1 -> TMR0 stays FEh for 2 strobes, then FFh, then 00h.
REQ-037 Write STATUS=07h with alu_upd=001b and C=0 in the same clk -> STATUS reads 1Eh.
REQ-038 Write PCL=40h -> one-clk pcl_we with pcl_wdata=40h; read addr 08h -> 00h; write FSR=00h then read INDF -> 00h.
REQ-039 Assert rst mid-count with OPTION=00h -> TMR0=00h, OPTION=FFh, STATUS reads 18h, FSR reads E0h, gpio_oe=0.
